// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
//   Generates the VGA scan raster: pixel-rate tick, column/row counters,
//   visible/hsync/vsync strobes and frame-level events. A start/stop handshake
//   stops the scan only at a frame boundary, so a stop never truncates a frame.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   enable       run request (1 = scan, 0 = finish current frame then idle)
//   pix_tick     one-clk pulse per pixel period
//   colPos       horizontal count, 0..H_TOTAL-1 (never delayed)
//   rowPos       vertical count, 0..V_TOTAL-1 (never delayed)
//   visible      inside the active area while running (SYNC_DELAY-delayed)
//   hsync        horizontal sync, SYNC_POL level when active (SYNC_DELAY-delayed)
//   vsync        vertical sync, SYNC_POL level when active (SYNC_DELAY-delayed)
//   frame_start  one-clk pulse in the clk the counters read (0,0) of a new frame
//   frame_count  completed-frame counter, modulo 256
//   running      high while scanning or draining the last frame
// ---------------------------------------------------------------------------
module vga_timing_ctrl #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int CLK_DIV    = 1,
    parameter int SYNC_DELAY = 0,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    output logic       pix_tick,
    output logic [9:0] colPos,
    output logic [9:0] rowPos,
    output logic       visible,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic       running
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [4:0] DIV_LAST = 5'(CLK_DIV - 1);

    // Elaboration-time parameter checks.
    if (H_TOTAL > 1024) begin : g_chk_h
        $error("vga_timing_ctrl: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_chk_v
        $error("vga_timing_ctrl: V_TOTAL exceeds 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_chk_div
        $error("vga_timing_ctrl: CLK_DIV must be 1..16");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_chk_dly
        $error("vga_timing_ctrl: SYNC_DELAY must be 0..4");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] div_q;
    logic       frame_wrap;
    logic       fs_d;

    assign running    = (state_q != IDLE);
    assign pix_tick   = running && (div_q == DIV_LAST);
    assign frame_wrap = pix_tick && (colPos == H_LAST) && (rowPos == V_LAST);

    // A wrap seen in RUN (or in DRAIN with enable back high) starts a new
    // frame and stays in RUN for at least that clk, so the last frame_start
    // is always followed by one complete frame.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // can leave it unassigned and infer a latch.
        state_d = state_q;
        fs_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    fs_d    = 1'b1;
                end
            end
            RUN: begin
                if (frame_wrap) begin
                    fs_d = 1'b1;
                end else if (!enable) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                    fs_d    = frame_wrap;
                end else if (frame_wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!reset_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            colPos      <= '0;
            rowPos      <= '0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q     <= state_d;
            frame_start <= fs_d;

            if (!running || pix_tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 5'd1;
            end

            // The last drained pixel wraps the counters to 0, which is
            // exactly the IDLE hold value.
            if (pix_tick) begin
                if (colPos == H_LAST) begin
                    colPos <= '0;
                    rowPos <= (rowPos == V_LAST) ? 10'd0 : rowPos + 10'd1;
                end else begin
                    colPos <= colPos + 10'd1;
                end
            end

            if (frame_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    // Active-high decodes straight from the registered counters:
    // {visible, hsync active, vsync active}.
    logic [2:0] act_now;
    logic [2:0] act_out;

    assign act_now = {
        running && (colPos < H_VIS) && (rowPos < V_VIS),
        running && (colPos >= HS_FIRST) && (colPos <= HS_LAST),
        running && (rowPos >= VS_FIRST) && (rowPos <= VS_LAST)
    };

    if (SYNC_DELAY == 0) begin : g_no_delay
        assign act_out = act_now;
    end else begin : g_delay
        logic [2:0] stage_q [SYNC_DELAY];

        always_ff @(posedge clk or negedge reset_n) begin
            // NOTE: the delay stages drive the sync pins, so every stage is
            // reset; otherwise stale levels would reach the monitor after reset.
            if (!reset_n) begin
                for (int i = 0; i < SYNC_DELAY; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= act_now;
                for (int i = 1; i < SYNC_DELAY; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign act_out = stage_q[SYNC_DELAY-1];
    end

    // Inactive sync level is ~SYNC_POL.
    assign visible = act_out[2];
    assign hsync   = act_out[1] ~^ SYNC_POL;
    assign vsync   = act_out[0] ~^ SYNC_POL;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_ctrl
//   Self-checking bench for vga_timing_ctrl using a reduced raster
//   (15 x 9 total, 8 x 5 visible) so whole frames stay short.
//     dut_a : CLK_DIV=1, SYNC_DELAY=0  -- full per-clk scoreboard
//     dut_b : CLK_DIV=3, SYNC_DELAY=0  -- directed divider measurements
//     dut_c : CLK_DIV=1, SYNC_DELAY=2  -- per-clk scoreboard, delayed strobes
// ---------------------------------------------------------------------------
module tb_vga_timing_ctrl;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 5, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;   // 15
    localparam int VT = VV + VF + VS + VB;   // 9
    localparam int FR = HT * VT;             // 135 clks per frame at CLK_DIV=1

    typedef struct packed {
        logic       pix_tick;
        logic [9:0] col;
        logic [9:0] row;
        logic       vis;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [7:0] fc;
        logic       run;
    } out_t;

    typedef struct {
        out_t a;
        out_t c;
    } sb_t;

    localparam logic [33:0] RST_BITS =
        {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};

    logic clk;
    logic reset_n;
    logic enable;

    logic       a_pix, a_vis, a_hs, a_vs, a_fs, a_run;
    logic [9:0] a_col, a_row;
    logic [7:0] a_fc;
    logic       b_pix, b_vis, b_hs, b_vs, b_fs, b_run;
    logic [9:0] b_col, b_row;
    logic [7:0] b_fc;
    logic       c_pix, c_vis, c_hs, c_vs, c_fs, c_run;
    logic [9:0] c_col, c_row;
    logic [7:0] c_fc;

    out_t obs_a, obs_b, obs_c;
    assign obs_a = {a_pix, a_col, a_row, a_vis, a_hs, a_vs, a_fs, a_fc, a_run};
    assign obs_b = {b_pix, b_col, b_row, b_vis, b_hs, b_vs, b_fs, b_fc, b_run};
    assign obs_c = {c_pix, c_col, c_row, c_vis, c_hs, c_vs, c_fs, c_fc, c_run};

    vga_timing_ctrl #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(1), .SYNC_DELAY(0), .SYNC_POL(1'b0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .pix_tick(a_pix), .colPos(a_col), .rowPos(a_row),
        .visible(a_vis), .hsync(a_hs), .vsync(a_vs),
        .frame_start(a_fs), .frame_count(a_fc), .running(a_run)
    );

    vga_timing_ctrl #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(3), .SYNC_DELAY(0), .SYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .pix_tick(b_pix), .colPos(b_col), .rowPos(b_row),
        .visible(b_vis), .hsync(b_hs), .vsync(b_vs),
        .frame_start(b_fs), .frame_count(b_fc), .running(b_run)
    );

    vga_timing_ctrl #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(1), .SYNC_DELAY(2), .SYNC_POL(1'b0)
    ) dut_c (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .pix_tick(c_pix), .colPos(c_col), .rowPos(c_row),
        .visible(c_vis), .hsync(c_hs), .vsync(c_vs),
        .frame_start(c_fs), .frame_count(c_fc), .running(c_run)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (CLK_DIV=1 raster) -----------------
    // State: 0 idle, 1 run, 2 drain; m_pix is the linear pixel index in frame.
    int       m_st  = 0;
    int       m_pix = 0;
    int       m_fc  = 0;
    bit       m_fs  = 1'b0;
    logic [2:0] m_d1 = 3'b000;
    logic [2:0] m_d2 = 3'b000;
    sb_t      sb[$];

    function automatic logic [2:0] m_act();
        int col = m_pix % HT;
        int row = m_pix / HT;
        bit run = (m_st != 0);
        return {run && col < HV && row < VV,
                run && col >= HV + HF && col < HV + HF + HS,
                run && row >= VV + VF && row < VV + VF + VS};
    endfunction

    function automatic out_t m_out(input logic [2:0] act);
        out_t o;
        o.pix_tick = (m_st != 0);
        o.col      = 10'(m_pix % HT);
        o.row      = 10'(m_pix / HT);
        o.vis      = act[2];
        o.hs       = ~act[1];
        o.vs       = ~act[0];
        o.fs       = m_fs;
        o.fc       = 8'(m_fc);
        o.run      = (m_st != 0);
        return o;
    endfunction

    task automatic m_step(input logic en);
        bit last = (m_pix == FR - 1);
        m_fs = 1'b0;
        case (m_st)
            0: if (en) begin m_st = 1; m_fs = 1'b1; end
            1: begin
                if (last) begin
                    m_pix = 0; m_fc = (m_fc + 1) % 256; m_fs = 1'b1;
                end else begin
                    m_pix++;
                    if (!en) m_st = 2;
                end
            end
            default: begin
                if (last) begin
                    m_pix = 0; m_fc = (m_fc + 1) % 256;
                    if (en) begin m_st = 1; m_fs = 1'b1; end
                    else m_st = 0;
                end else begin
                    m_pix++;
                    if (en) m_st = 1;
                end
            end
        endcase
    endtask

    // Producer: one expectation per clk edge (or async reset), for the
    // outputs the DUTs show after that event.
    initial begin : model
        sb_t item;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_st = 0; m_pix = 0; m_fc = 0; m_fs = 1'b0;
                m_d1 = 3'b000; m_d2 = 3'b000;
                sb.delete();
            end else begin
                m_d2 = m_d1;
                m_d1 = m_act();
                m_step(enable);
            end
            item.a = m_out(m_act());
            item.c = m_out(m_d2);
            sb.push_back(item);
        end
    end

    // Consumer: compare mid-cycle, away from the active edge.
    initial begin : monitor
        sb_t item;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                item = sb.pop_front();
                check("scan_a", 64'(obs_a), 64'(item.a));
                check("scan_c", 64'(obs_c), 64'(item.c));
            end
        end
    end

    // ---------------- helpers --------------------------------------------
    task automatic wait_pos(input int row, input int col, input string tag);
        int n = 0;
        while (!(a_row == 10'(row) && a_col == 10'(col)) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reached"}, 64'(a_row == 10'(row) && a_col == 10'(col)), 64'd1);
    endtask

    task automatic wait_fs(input bit use_b, input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(use_b ? b_fs : a_fs) && n < budget);
        check({tag, "_seen"}, 64'(use_b ? b_fs : a_fs), 64'd1);
    endtask

    // ---------------- directed stimulus ----------------------------------
    initial begin : stim
        int period, hs_cnt, hs_first, vs_cnt, vs_first, vis_cnt;
        int tick_cnt, bad_gap, since, col_chg, n, fs_seen, bad, stopped;
        logic [9:0] prev_col, prev_row;
        logic [7:0] fc_exp;

        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_a", 64'(obs_a), 64'(RST_BITS));
        check("rst_b", 64'(obs_b), 64'(RST_BITS));
        check("rst_c", 64'(obs_c), 64'(RST_BITS));
        @(negedge clk);
        #2 reset_n = 1'b1;

        // Idle holds with enable low.
        repeat (3) @(negedge clk);
        check("idle_hold", 64'(obs_a), 64'(RST_BITS));

        // Start: frame_start in the first RUN clk at (0,0), visible.
        enable = 1'b1;
        wait_fs(1'b0, 4, "start_fs");
        check("start_pos", {a_col, a_row, a_vis, a_run}, {10'd0, 10'd0, 1'b1, 1'b1});

        // One full frame of dut_a: sync widths/positions, visible count, period.
        period = 0; hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first = -1; vis_cnt = 0;
        do begin
            if (!a_hs && a_row == 10'd0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(a_col);
            end
            if (!a_vs) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = int'(a_row);
            end
            if (a_vis) vis_cnt++;
            @(negedge clk);
            period++;
        end while (!a_fs && period < 1000);
        check("a_frame_period", period, FR);
        check("a_hsync_width", hs_cnt, HS);
        check("a_hsync_start", hs_first, HV + HF);
        check("a_vsync_clks", vs_cnt, VS * HT);
        check("a_vsync_start", vs_first, VV + VF);
        check("a_visible_clks", vis_cnt, HV * VV);

        // dut_b, CLK_DIV=3: tick spacing, pixel hold, frame period, hsync width.
        wait_fs(1'b1, 1000, "b_fs");
        period = 0; tick_cnt = 0; bad_gap = 0; since = 0; hs_cnt = 0; col_chg = 0;
        prev_col = b_col;
        do begin
            if (b_pix) begin
                tick_cnt++;
                if (since != 2) bad_gap++;
                since = 0;
            end else begin
                since++;
            end
            if (!b_hs && b_row == 10'd0) hs_cnt++;
            @(negedge clk);
            period++;
            if (b_col != prev_col) col_chg++;
            prev_col = b_col;
        end while (!b_fs && period < 2000);
        check("b_frame_period", period, 3 * FR);
        check("b_tick_count", tick_cnt, FR);
        check("b_tick_gap", bad_gap, 0);
        check("b_col_changes", col_chg, FR);
        check("b_hsync_width", hs_cnt, 3 * HS);

        // Drop enable mid-frame: drain to the wrap, then idle.
        wait_pos(2, 0, "drop_pos");
        fc_exp  = a_fc + 8'd1;
        enable  = 1'b0;
        n = 0; fs_seen = 0; prev_col = a_col; prev_row = a_row;
        while (a_run && n < 300) begin
            prev_col = a_col;
            prev_row = a_row;
            @(negedge clk);
            n++;
            if (a_fs) fs_seen++;
        end
        check("drain_len", n, FR - 2 * HT);
        check("drain_last_pos", {prev_row, prev_col}, {10'(VT - 1), 10'(HT - 1)});
        check("drain_idle_pos", {a_run, a_row, a_col}, 21'd0);
        check("drain_fc", a_fc, fc_exp);
        check("drain_no_fs", fs_seen, 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_run || a_vis || !a_hs || !a_vs || a_pix || a_fs ||
                a_col != 10'd0 || a_row != 10'd0) bad++;
        end
        check("idle_quiet", bad, 0);

        // Drop and re-raise within one frame: no stop, normal wrap.
        enable = 1'b1;
        wait_fs(1'b0, 4, "rerun_fs");
        fc_exp = a_fc + 8'd1;
        period = 0; stopped = 0;
        do begin
            if (a_col == 10'd0 && a_row == 10'd2) enable = 1'b0;
            if (a_col == 10'd0 && a_row == 10'd4) enable = 1'b1;
            if (!a_run) stopped++;
            @(negedge clk);
            period++;
        end while (!a_fs && period < 1000);
        check("rerun_period", period, FR);
        check("rerun_no_stop", stopped, 0);
        check("rerun_fc", a_fc, fc_exp);

        // Enable drops in the wrap clk: frame_start still pulses, full frame follows.
        wait_pos(VT - 1, HT - 1, "sim_pos");
        enable = 1'b0;
        @(negedge clk);
        check("sim_fs", {a_fs, a_run, a_col, a_row}, {1'b1, 1'b1, 20'd0});
        n = 0;
        while (a_run && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("sim_full_frame", n, FR);

        // Asynchronous reset mid-frame.
        enable = 1'b1;
        wait_fs(1'b0, 4, "rst_run_fs");
        wait_pos(3, 5, "rst_pos");
        check("pre_rst_c_active", {c_vis, c_run}, 2'b11);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_a", 64'(obs_a), 64'(RST_BITS));
        check("async_rst_b", 64'(obs_b), 64'(RST_BITS));
        check("async_rst_c", 64'(obs_c), 64'(RST_BITS));
        @(negedge clk);
        #2 reset_n = 1'b1;

        // 256 frames: frame_count wraps 255 -> 0.
        n = 0;
        while (a_fc != 8'd255 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check("fc_reach_255", a_fc, 8'd255);
        wait_fs(1'b0, 300, "fc_wrap_fs");
        check("fc_wrap", a_fc, 8'd0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
